// File: rtl/arb_pkg.sv
// Shared encodings and default widths for the cache/memory arbiter.
package arb_pkg;

  localparam int ADDR_W_DEF       = 28;
  localparam int LINE_W_DEF       = 128;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_e;

  function automatic logic is_grant(arb_state_e s);
    return (s == GRANT_I) || (s == GRANT_D);
  endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// Counts D grants taken while an I refill waits; raises force_i_o once the limit is hit.
module arb_starve_counter
  import arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_grant_i,
  input  logic i_grant_i,
  input  logic i_pend_i,
  output logic force_i_o
);

  logic [STARVE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_grant_i) begin
      cnt_d = '0;
    end else if (d_grant_i && i_pend_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_i_o = i_pend_i && (cnt_q >= STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/cache_mem_arbiter.sv
// Single-port memory arbiter for I-cache refill and D-cache refill/write-back, D priority.
// Define ARB_STARVE_GUARD_EN to let a waiting I refill win after STARVE_LIMIT D grants.
module cache_mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int LINE_W       = LINE_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
    $error("STARVE_LIMIT must fit the 3-bit starvation counter");
  end

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  arb_op_e           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

  logic d_req, force_i, pick_d, pick_i, take_d, take_i;

  assign d_req  = d_mem_read | d_mem_write;
  assign pick_d = d_req & ~force_i;
  assign pick_i = i_mem_read & ~pick_d;
  assign take_d = (state_q == IDLE) & pick_d;
  assign take_i = (state_q == IDLE) & pick_i;

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_grant_i(take_d),
    .i_grant_i(take_i),
    .i_pend_i (i_mem_read),
    .force_i_o(force_i)
  );
`else
  assign force_i = 1'b0;
`endif

  // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (pick_d) begin
          owner_d = OWN_D;
          op_d    = d_mem_write ? OP_WRITE : OP_READ;  // write-back before refill
          addr_d  = d_mem_addr;
          wdata_d = d_mem_wdata;
          state_d = GRANT_D;
        end else if (pick_i) begin
          owner_d = OWN_I;
          op_d    = OP_READ;
          addr_d  = i_mem_addr;
          wdata_d = '0;
          state_d = GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready) begin
          state_d = RESP;
          if (op_q == OP_READ) begin
            if (owner_q == OWN_I) i_rdata_d = mem_rdata;
            else                  d_rdata_d = mem_rdata;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the line registers are reset too, because their outputs must read 0 after reset.
  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign mem_read    = is_grant(state_q) && (op_q == OP_READ);
  assign mem_write   = is_grant(state_q) && (op_q == OP_WRITE);
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign i_mem_rdata = i_rdata_q;
  assign d_mem_rdata = d_rdata_q;
  assign i_mem_ready = (state_q == RESP) && (owner_q == OWN_I);
  assign d_mem_ready = (state_q == RESP) && (owner_q == OWN_D);
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized request mixes vs a priority-queue model.
module tb_cache_mem_arbiter;

  localparam int ADDR_W       = 28;
  localparam int LINE_W       = 128;
  localparam int STARVE_LIMIT = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_mem_read;
  logic [ADDR_W-1:0] i_mem_addr;
  logic [LINE_W-1:0] i_mem_rdata;
  logic              i_mem_ready;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [ADDR_W-1:0] d_mem_addr;
  logic [LINE_W-1:0] d_mem_wdata;
  logic [LINE_W-1:0] d_mem_rdata;
  logic              d_mem_ready;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              busy;

  cache_mem_arbiter #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: last line returned to each cache, starvation run length.
  logic [LINE_W-1:0] exp_i_rd;
  logic [LINE_W-1:0] exp_d_rd;
  int                starve;
  bit                hold_d;

  typedef enum int {W_I, W_DR, W_DW, W_NONE} win_e;

  task automatic check_v(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  function automatic win_e predict();
`ifdef ARB_STARVE_GUARD_EN
    if (i_mem_read && starve >= STARVE_LIMIT) return W_I;
`endif
    if (d_mem_write) return W_DW;
    if (d_mem_read)  return W_DR;
    if (i_mem_read)  return W_I;
    return W_NONE;
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called on a negedge with the DUT in IDLE and at least one request raised.
  task automatic do_txn(input int lat, input bit drop_early, input logic [LINE_W-1:0] line,
                        output win_e w);
    logic [ADDR_W-1:0] eaddr;
    logic [LINE_W-1:0] ewdata;
    int waited;
    w      = predict();
    eaddr  = (w == W_I) ? i_mem_addr : d_mem_addr;
    ewdata = d_mem_wdata;
    if (w == W_I) starve = 0;
    else if (i_mem_read && starve < 7) starve++;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(mem_read || mem_write) && waited < 4);
    check_v("grant_latency", 128'(waited), 128'(1));
    if (!(mem_read || mem_write)) return;
    check("mem_read", mem_read, w != W_DW);
    check("mem_write", mem_write, w == W_DW);
    check_v("mem_addr", 128'(mem_addr), 128'(eaddr));
    if (w == W_DW) check_v("mem_wdata", mem_wdata, ewdata);
    check("busy_grant", busy, 1'b1);
    if (drop_early) begin
      case (w)
        W_I:     i_mem_read  = 1'b0;
        W_DR:    d_mem_read  = 1'b0;
        W_DW:    d_mem_write = 1'b0;
        default: ;
      endcase
    end
    repeat (lat) @(negedge clk);
    check("strobe_hold", mem_read | mem_write, 1'b1);
    mem_rdata = line;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = rand_line();
    if (w == W_I)  exp_i_rd = line;
    if (w == W_DR) exp_d_rd = line;
    check("i_ready", i_mem_ready, w == W_I);
    check("d_ready", d_mem_ready, w != W_I);
    check_v("i_rdata", i_mem_rdata, exp_i_rd);
    check_v("d_rdata", d_mem_rdata, exp_d_rd);
    check("strobe_drop", mem_read | mem_write, 1'b0);
    case (w)
      W_I:     i_mem_read = 1'b0;
      W_DR:    if (!hold_d) d_mem_read = 1'b0;
      W_DW:    d_mem_write = 1'b0;
      default: ;
    endcase
    @(negedge clk);
    check("ready_one_cycle", i_mem_ready | d_mem_ready, 1'b0);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    win_e w;
    int   n_i;
    int   n_d;
    rst_n       = 1'b1;
    i_mem_read  = 1'b0;
    i_mem_addr  = '0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_mem_addr  = '0;
    d_mem_wdata = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;
    hold_d      = 1'b0;
    exp_i_rd    = '0;
    exp_d_rd    = '0;
    starve      = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_mem_read", mem_read, 1'b0);
    check("rst_mem_write", mem_write, 1'b0);
    check_v("rst_mem_addr", 128'(mem_addr), 128'(0));
    check_v("rst_mem_wdata", mem_wdata, 128'(0));
    check_v("rst_i_rdata", i_mem_rdata, 128'(0));
    check_v("rst_d_rdata", d_mem_rdata, 128'(0));
    check("rst_i_ready", i_mem_ready, 1'b0);
    check("rst_d_ready", d_mem_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);

    // Single I refill
    i_mem_addr = 28'h0000010;
    i_mem_read = 1'b1;
    do_txn(2, 1'b0, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D}, w);

    // Simultaneous I and D refill: D first, then I
    i_mem_addr = 28'h0000100;
    d_mem_addr = 28'h0000200;
    i_mem_read = 1'b1;
    d_mem_read = 1'b1;
    do_txn(1, 1'b0, rand_line(), w);
    do_txn(0, 1'b0, rand_line(), w);

    // D read and write together: write-back, then refill
    d_mem_addr  = 28'h0000020;
    d_mem_wdata = {16{8'hA5}};
    d_mem_read  = 1'b1;
    d_mem_write = 1'b1;
    do_txn(1, 1'b0, rand_line(), w);
    do_txn(2, 1'b0, rand_line(), w);

    // Stray mem_ready while idle
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("stray_i_ready", i_mem_ready, 1'b0);
    check("stray_d_ready", d_mem_ready, 1'b0);
    check("stray_busy", busy, 1'b0);
    @(negedge clk);
    check("stray_ready_late", i_mem_ready | d_mem_ready, 1'b0);

    // Reset in the middle of a D refill
    d_mem_addr = 28'h0000300;
    d_mem_read = 1'b1;
    @(negedge clk);
    check("pre_rst_mem_read", mem_read, 1'b1);
    #2 rst_n = 1'b1;
    #1;
    check("async_rst_mem_read", mem_read, 1'b0);
    check("async_rst_busy", busy, 1'b0);
    check_v("async_rst_d_rdata", d_mem_rdata, 128'(0));
    d_mem_read = 1'b0;
    exp_i_rd   = '0;
    exp_d_rd   = '0;
    starve     = 0;
    mem_ready  = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abandoned_no_ready", d_mem_ready | i_mem_ready, 1'b0);
      check("abandoned_idle", busy, 1'b0);
    end

    // Continuous D traffic while I waits
    i_mem_addr = 28'h0000400;
    d_mem_addr = 28'h0000500;
    i_mem_read = 1'b1;
    d_mem_read = 1'b1;
    hold_d     = 1'b1;
    n_i        = 0;
    n_d        = 0;
    repeat (6) begin
      do_txn(0, 1'b0, rand_line(), w);
      if (w == W_I) n_i++;
      else n_d++;
    end
`ifdef ARB_STARVE_GUARD_EN
    check_v("starve_i_grants", 128'(n_i), 128'(1));
`else
    check_v("starve_i_grants", 128'(n_i), 128'(0));
    check("i_still_waiting", i_mem_ready, 1'b0);
`endif
    hold_d = 1'b0;
    for (int k = 0; k < 4 && (i_mem_read || d_mem_read || d_mem_write); k++) begin
      do_txn(0, 1'b0, rand_line(), w);
    end

    // Randomized request mixes, including requesters that drop mid-transaction
    for (int t = 0; t < 30; t++) begin
      i_mem_addr  = ADDR_W'($urandom);
      d_mem_addr  = ADDR_W'($urandom);
      d_mem_wdata = rand_line();
      i_mem_read  = 1'($urandom);
      d_mem_read  = 1'($urandom);
      d_mem_write = 1'($urandom);
      for (int k = 0; k < 4 && (i_mem_read || d_mem_read || d_mem_write); k++) begin
        do_txn(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), rand_line(), w);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single off-chip memory port between the I-cache refill path and the D-cache refill/write-back path of the five-stage pipeline core.
- Sits between the two 1-level caches and the memory model.
- Latches one request at a time, sequences it to memory, returns data and a one-cycle ready pulse to the owner.
- Default policy is D-cache priority, so loads/stores drain ahead of fetch.

Parameters:
ADDR_W, 28, block address width (128-bit lines)
LINE_W, 128, line data width
STARVE_LIMIT, 4, consecutive D grants allowed while I waits (only with guard enabled)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous reset, active-high (asserted = 1); name kept per codebase convention
i_mem_read  input  1  I-cache refill request, held until i_mem_ready
i_mem_addr  input  ADDR_W  I-cache block address
i_mem_rdata  output  LINE_W  refill line to I-cache
i_mem_ready  output  1  one-cycle completion pulse to I-cache
d_mem_read  input  1  D-cache refill request
d_mem_write  input  1  D-cache write-back request
d_mem_addr  input  ADDR_W  D-cache block address
d_mem_wdata  input  LINE_W  write-back line
d_mem_rdata  output  LINE_W  refill line to D-cache
d_mem_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read strobe, held until mem_ready
mem_write  output  1  memory write strobe, held until mem_ready
mem_addr  output  ADDR_W  memory block address
mem_wdata  output  LINE_W  memory write line
mem_rdata  input  LINE_W  memory read line, valid with mem_ready
mem_ready  input  1  memory completion pulse
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=1): state IDLE; all outputs 0; starvation counter 0; latched request cleared. Reset mid-transaction abandons it, drops mem_read/mem_write immediately, and issues no ready pulse.
- FSM: IDLE -> GRANT_I | GRANT_D -> RESP -> IDLE.
- IDLE:
  - Sample requests each cycle.
  - Pick winner: D if d_mem_read|d_mem_write, else I if i_mem_read.
  - Latch addr, wdata, op and owner into registers; next state GRANT_x.
- GRANT_x:
  - mem_read/mem_write/mem_addr/mem_wdata are driven from the latched registers; they are stable for the whole transaction.
  - On mem_ready: capture mem_rdata into the owner's rdata register, deassert strobes in the same edge, go to RESP.
- RESP:
  - Owner's ready = 1 for exactly one cycle; rdata is held until that owner's next completion.
  - The other ready stays 0. Next state IDLE.
- Latency: request visible at cycle t -> mem strobe at t+1; mem_ready at t+k -> cache ready at t+k+1. Minimum back-to-back turnaround is one IDLE cycle.
- d_mem_read and d_mem_write both high: write wins (write-back before refill). The read is served on a later arbitration.
- Requester deasserting mid-transaction: the transaction still completes and the ready pulse is still issued.
- A request arriving during RESP is not sampled until IDLE.
- Write transactions: d_mem_rdata is left unchanged; d_mem_ready still pulses.
- mem_ready while IDLE or RESP: ignored.
- busy = (state != IDLE).

Optional Feature:
ARB_STARVE_GUARD_EN
- Defined:
  - A 3-bit saturating counter increments on each D grant taken while i_mem_read is pending; it clears on any I grant.
  - When the counter reaches STARVE_LIMIT and i_mem_read is high, I wins the next arbitration regardless of D.
- Undefined: strict D priority; no counter logic.

Decomposition:
- Shared package arb_pkg: state encoding (IDLE=2'd0, GRANT_I=2'd1, GRANT_D=2'd2, RESP=2'd3), owner encoding (OWN_I=1'b0, OWN_D=1'b1), op encoding, default widths.
- One natural sub-module, arb_starve_counter: counter plus force-I flag. It is instantiated only under ARB_STARVE_GUARD_EN.

Test Plan:
- Reset: rst_n pulsed mid-GRANT_D with mem_read=1 -> mem_read=0 asynchronously; d_mem_ready never pulses; busy=0.
- Single I refill: i_mem_read=1, addr=0x0000010; memory answers 3 cycles later with rdata=0xDEADBEEF_... -> mem_read=1 with mem_addr=0x0000010; i_mem_ready one cycle after mem_ready; i_mem_rdata equals the line.
- Simultaneous: i_mem_read and d_mem_read both high in IDLE -> D served first, then I; exactly one ready pulse each, in that order.
- D read+write together: addr=0x0000020, wdata=0xA5... -> mem_write served first with wdata 0xA5...; d_mem_ready pulses; the read follows as a separate transaction.
- Starvation, with ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: D requests continuously while I waits -> 4 D grants, then an I grant, then D resumes. Without the macro, I stays ungranted while D is continuous.
- Stray mem_ready while IDLE -> no ready pulse, state remains IDLE.
